// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point adder/subtractor with a
// valid/ready handshake. Exponent and mantissa widths are parameters; the
// number format is {sign, biased exponent, stored mantissa} with an implicit
// hidden bit. Rounding is round-to-nearest-even using guard/round/sticky bits.
// Denormal inputs are flushed to zero and tiny results flush to signed zero.
//
// Stages: 1 align (order by magnitude, shift the small operand),
//         2 add (magnitude add/subtract, leading-zero count),
//         3 normalise / round / pack into the output register.
//
// Optional feature macro: FP_ADD_PIPE_FLAGS_EN adds the `flags` port
// {invalid, overflow, inexact} and the logic that produces it.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   operands accepted this cycle (pipeline advancing)
//   a, b       operands {sign, exp, man}
//   sub        1: a - b, 0: a + b
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   res        packed result
//   flags      {invalid, overflow, inexact} (FP_ADD_PIPE_FLAGS_EN only)
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res
`ifdef FP_ADD_PIPE_FLAGS_EN
  ,
  output logic [2:0]             flags
`endif
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;            // {hidden, man, G, R, S}
  localparam int LZW = $clog2(SW + 1);
  localparam int EW2 = EXP_W + 2;            // signed exponent with headroom
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------- stage 1
  logic               sign_a, sign_b;
  logic [EXP_W-1:0]   exp_a, exp_b;
  logic [MAN_W-1:0]   man_a, man_b;
  logic               nan_a, nan_b, inf_a, inf_b;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1] ^ sub;
  assign exp_a  = a[W-2:MAN_W];
  assign exp_b  = b[W-2:MAN_W];
  // Exponent field 0 is zero: the stored mantissa of a denormal is dropped.
  assign man_a  = (exp_a == '0) ? '0 : a[MAN_W-1:0];
  assign man_b  = (exp_b == '0) ? '0 : b[MAN_W-1:0];
  assign nan_a  = (exp_a == EXP_ONES) && (man_a != '0);
  assign nan_b  = (exp_b == EXP_ONES) && (man_b != '0);
  assign inf_a  = (exp_a == EXP_ONES) && (man_a == '0);
  assign inf_b  = (exp_b == EXP_ONES) && (man_b == '0);

  logic               c1_sign_l, c1_sign_s;
  logic [EXP_W-1:0]   c1_exp_l, c1_exp_s, c1_d;
  logic [MAN_W-1:0]   c1_man_l, c1_man_s;
  logic [SW-1:0]      c1_sig_l, c1_sig_s_raw, c1_sig_s;
  logic               c1_lost;
  logic               c1_spec;
  logic [W-1:0]       c1_spec_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
  logic               c1_spec_inv;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    c1_spec     = nan_a || nan_b || inf_a || inf_b;
    c1_spec_res = QNAN;
`ifdef FP_ADD_PIPE_FLAGS_EN
    c1_spec_inv = 1'b0;
`endif
    if (nan_a || nan_b) begin
      c1_spec_res = QNAN;
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      c1_spec_res = QNAN;
`ifdef FP_ADD_PIPE_FLAGS_EN
      c1_spec_inv = 1'b1;
`endif
    end else if (inf_a) begin
      c1_spec_res = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      c1_spec_res = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // Largest magnitude goes first so stage 2 never produces a negative result.
  always_comb begin
    if ({exp_a, man_a} >= {exp_b, man_b}) begin
      c1_sign_l = sign_a; c1_exp_l = exp_a; c1_man_l = man_a;
      c1_sign_s = sign_b; c1_exp_s = exp_b; c1_man_s = man_b;
    end else begin
      c1_sign_l = sign_b; c1_exp_l = exp_b; c1_man_l = man_b;
      c1_sign_s = sign_a; c1_exp_s = exp_a; c1_man_s = man_a;
    end
    c1_d         = c1_exp_l - c1_exp_s;
    c1_sig_l     = {c1_exp_l != '0, c1_man_l, 3'b000};
    c1_sig_s_raw = {c1_exp_s != '0, c1_man_s, 3'b000};
    // Bits pushed below the sticky position are ORed into it. For shifts of
    // SW-1 or more this collapses the whole small operand into S.
    c1_lost = 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (i < int'(c1_d)) c1_lost = c1_lost | c1_sig_s_raw[i];
    end
    c1_sig_s = (c1_sig_s_raw >> c1_d) | {{(SW-1){1'b0}}, c1_lost};
  end

  logic               s1_valid, s1_sign_l, s1_sign_s, s1_spec;
  logic [EXP_W-1:0]   s1_exp_l;
  logic [SW-1:0]      s1_sig_l, s1_sig_s;
  logic [W-1:0]       s1_spec_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
  logic               s1_spec_inv;
`endif

  // ---------------------------------------------------------------- stage 2
  logic [SW:0]        c2_sum;
  logic [LZW-1:0]     c2_lzc;

  always_comb begin
    if (s1_sign_l ^ s1_sign_s) c2_sum = {1'b0, s1_sig_l} - {1'b0, s1_sig_s};
    else                       c2_sum = {1'b0, s1_sig_l} + {1'b0, s1_sig_s};
    // Leading zeros below the carry bit; the highest set bit wins.
    c2_lzc = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (c2_sum[i]) c2_lzc = LZW'(SW - 1 - i);
    end
  end

  logic               s2_valid, s2_sign, s2_zero_sign, s2_spec;
  logic [EXP_W-1:0]   s2_exp_l;
  logic [SW:0]        s2_sum;
  logic [LZW-1:0]     s2_lzc;
  logic [W-1:0]       s2_spec_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
  logic               s2_spec_inv;
`endif

  // ---------------------------------------------------------------- stage 3
  logic [SW-1:0]          c3_norm;
  logic signed [EW2-1:0]  c3_exp_n, c3_exp_f;
  logic [MAN_W+1:0]       c3_mant_r;
  logic [MAN_W-1:0]       c3_man_f;
  logic                   c3_g, c3_r, c3_s, c3_up;
  logic [W-1:0]           c3_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
  logic [2:0]             c3_flags;
`endif

  always_comb begin
    if (s2_sum[SW]) begin
      // Carry out: the dropped LSB folds into sticky.
      c3_norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      c3_exp_n = EW2'(s2_exp_l) + EW2'(1);
    end else begin
      c3_norm  = s2_sum[SW-1:0] << s2_lzc;
      c3_exp_n = EW2'(s2_exp_l) - EW2'(s2_lzc);
    end
    c3_g      = c3_norm[2];
    c3_r      = c3_norm[1];
    c3_s      = c3_norm[0];
    c3_up     = c3_g && (c3_r || c3_s || c3_norm[3]);
    c3_mant_r = {1'b0, c3_norm[SW-1:3]} + (MAN_W+2)'(c3_up);
    // Rounding carry leaves 1.000..0, one binade up.
    c3_exp_f  = c3_exp_n + EW2'(c3_mant_r[MAN_W+1]);
    c3_man_f  = c3_mant_r[MAN_W+1] ? c3_mant_r[MAN_W:1] : c3_mant_r[MAN_W-1:0];

    c3_res = {s2_sign, c3_exp_f[EXP_W-1:0], c3_man_f};
`ifdef FP_ADD_PIPE_FLAGS_EN
    c3_flags = {1'b0, 1'b0, c3_g || c3_r || c3_s};
`endif
    if (s2_spec) begin
      c3_res = s2_spec_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
      c3_flags = {s2_spec_inv, 2'b00};
`endif
    end else if (s2_sum == '0) begin
      // Exact zero: negative only when both operands were negative.
      c3_res = {s2_zero_sign, {(W-1){1'b0}}};
`ifdef FP_ADD_PIPE_FLAGS_EN
      c3_flags = 3'b000;
`endif
    end else if (c3_exp_n <= 0) begin
      c3_res = {s2_sign, {(W-1){1'b0}}};
`ifdef FP_ADD_PIPE_FLAGS_EN
      c3_flags = 3'b001;
`endif
    end else if (int'(c3_exp_f) >= (2**EXP_W) - 1) begin
      c3_res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
`ifdef FP_ADD_PIPE_FLAGS_EN
      c3_flags = 3'b011;
`endif
    end
  end

  // ------------------------------------------------------------- registers
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge value of its source regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
`ifdef FP_ADD_PIPE_FLAGS_EN
      flags     <= '0;
`endif
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        res   <= c3_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
        flags <= c3_flags;
`endif
      end
    end
  end

  // NOTE: datapath payload registers carry no reset; they are qualified by
  // the valid bits above, which are reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      if (in_valid) begin
        s1_sign_l   <= c1_sign_l;
        s1_sign_s   <= c1_sign_s;
        s1_exp_l    <= c1_exp_l;
        s1_sig_l    <= c1_sig_l;
        s1_sig_s    <= c1_sig_s;
        s1_spec     <= c1_spec;
        s1_spec_res <= c1_spec_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
        s1_spec_inv <= c1_spec_inv;
`endif
      end
      if (s1_valid) begin
        s2_sign      <= s1_sign_l;
        s2_zero_sign <= s1_sign_l & s1_sign_s;
        s2_exp_l     <= s1_exp_l;
        s2_sum       <= c2_sum;
        s2_lzc       <= c2_lzc;
        s2_spec      <= s1_spec;
        s2_spec_res  <= s1_spec_res;
`ifdef FP_ADD_PIPE_FLAGS_EN
        s2_spec_inv  <= s1_spec_inv;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Testbench for fp_add_pipe (EXP_W=8, MAN_W=23). Expected results come from
// an exact wide-integer model of the addition with round-to-nearest-even;
// literal vectors pin that model. One negedge process checks every result
// that leaves the DUT against the in-order expectation queue.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, res;
`ifdef FP_ADD_PIPE_FLAGS_EN
  logic [2:0]  flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  logic [34:0] sb[$];   // {flags, res} in issue order

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
`ifdef FP_ADD_PIPE_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact model: both operands scaled to integers, added exactly, then
  // rounded to 24 significant bits (RNE) with flush/overflow rules.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic        sx, sy, sg, inexact, up;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic [299:0] mx, my, mag, mant, rem, half, one;
    int p, e;
    sx = x[31]; ex = x[30:23]; fx = x[22:0];
    sy = y[31] ^ s; ey = y[30:23]; fy = y[22:0];
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0)) return {3'b000, 32'h7FC00000};
    if (ex == 8'hFF && ey == 8'hFF && sx != sy) return {3'b100, 32'h7FC00000};
    if (ex == 8'hFF) return {3'b000, sx, 8'hFF, 23'h0};
    if (ey == 8'hFF) return {3'b000, sy, 8'hFF, 23'h0};
    one = 300'd1;
    mx = (ex == 0) ? '0 : (300'({1'b1, fx}) << ex);
    my = (ey == 0) ? '0 : (300'({1'b1, fy}) << ey);
    if (sx == sy)      begin mag = mx + my; sg = sx; end
    else if (mx >= my) begin mag = mx - my; sg = sx; end
    else               begin mag = my - mx; sg = sy; end
    if (mag == 0) return {3'b000, sx & sy, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 23;
    if (e <= 0) return {3'b001, sg, 31'h0};
    mant = mag >> e;
    rem  = mag & ((one << e) - one);
    half = one << (e - 1);
    inexact = (rem != 0);
    up = (rem > half) || (rem == half && mant[0]);
    mant = mant + 300'(up);
    if (mant[24]) begin mant = mant >> 1; e++; end
    if (e >= 255) return {3'b011, sg, 8'hFF, 23'h0};
    return {2'b00, inexact, sg, 8'(e), mant[22:0]};
  endfunction

  // Compare process: a beat transfers at the next posedge when valid&&ready.
  always @(negedge clk) begin
    logic [34:0] exp_v;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_output: got res 0x%0h with no operation outstanding", res);
        end else begin
          exp_v = sb.pop_front();
          n_out++;
          check($sformatf("res[%0d]", n_out), {32'h0, res}, {32'h0, exp_v[31:0]});
`ifdef FP_ADD_PIPE_FLAGS_EN
          check($sformatf("flags[%0d]", n_out), {61'h0, flags}, {61'h0, exp_v[34:32]});
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, sub));
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tsub);
    int budget = 0;
    a = ta; b = tb; sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 100) begin @(negedge clk); budget++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", budget);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    check(name, 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] bp_a[5];
  logic [31:0] bp_b[5];

  initial begin
    logic [34:0] m;
    int acc, k, base, seen;

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_res", {32'h0, res}, 64'd0);
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);
`ifdef FP_ADD_PIPE_FLAGS_EN
    check("rst_flags", {61'h0, flags}, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: one operation, result visible in the third cycle after accept.
    send(32'h3F800000, 32'h3F800000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("latency_c%0d", i + 1), {63'h0, out_valid}, (i == 2) ? 64'd1 : 64'd0);
    end
    check("latency_res", {32'h0, res}, 64'h40000000);
    @(posedge clk); #1;
    drain("latency_drain");

    // Directed vectors, issued back to back.
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000});
    vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000});
    vecs.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3'b000});
    vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'hBF7FFFFF, 1'b0, 32'h33800000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 3'b000});
    vecs.push_back('{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 3'b011});
    vecs.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001});
    vecs.push_back('{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b001});
    vecs.push_back('{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001});
    vecs.push_back('{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000});
    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].sub);
      check($sformatf("model_res_v%0d", i), {32'h0, m[31:0]}, {32'h0, vecs[i].r});
      check($sformatf("model_flags_v%0d", i), {61'h0, m[34:32]}, {61'h0, vecs[i].f});
    end
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].sub);
    drain("vec_drain");

    // Backpressure: 5 ops offered with out_ready low; only 3 fit.
    bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0A00000};
    bp_b = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h33800000, 32'h40400000};
    base = n_out;
    out_ready = 1'b0;
    k = 0; acc = 0;
    a = bp_a[0]; b = bp_b[0]; sub = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (acc > k) begin
        k = acc;
        if (k < 5) begin a = bp_a[k]; b = bp_b[k]; end else in_valid = 1'b0;
      end
    end
    check("bp_accepted", 64'(acc), 64'd3);
    @(negedge clk);
    check("bp_out_valid_held", {63'h0, out_valid}, 64'd1);
    check("bp_in_ready_low", {63'h0, in_ready}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_stream_c%0d", c), {63'h0, out_valid}, 64'd1);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (acc > k) begin
        k = acc;
        if (k < 5) begin a = bp_a[k]; b = bp_b[k]; end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(k), 64'd5);
    drain("bp_drain");
    check("bp_out_count", 64'(n_out - base), 64'd5);

    // Reset with operations in flight.
    send(32'h40000000, 32'h40000000, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_out_valid", {63'h0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("mid_rst_res", {32'h0, res}, 64'd0);
`ifdef FP_ADD_PIPE_FLAGS_EN
    check("mid_rst_flags", {61'h0, flags}, 64'd0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_after_rst", 64'(seen), 64'd0);

    // Pipeline still usable after reset.
    @(posedge clk); #1;
    send(32'h3F800000, 32'h3F800000, 1'b0);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshake.
- Generalises the single-precision combinational adder datapath to any exponent/mantissa width.
- Adds a subtract mode, full round-to-nearest-even with guard/round/sticky bits, special-value handling and backpressure.
- Sits between operand issue logic and the result writeback of the FP unit.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa field width (hidden bit implicit)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
a  input  1+EXP_W+MAN_W  operand A {sign, exp, man}
b  input  1+EXP_W+MAN_W  operand B
sub  input  1  1: compute a-b (invert b sign); 0: a+b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
res  output  1+EXP_W+MAN_W  packed result
flags  output  3  {invalid, overflow, inexact}; present only with FP_ADD_PIPE_FLAGS_EN

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all stage valid bits = 0; out_valid = 0; res = 0; flags = 0. Reset mid-operation discards all in-flight operations.
- Pipeline control: advance = !out_valid || out_ready. in_ready = advance (combinational).
  - Accept occurs when in_valid && in_ready.
  - When advance = 0, all stages hold.
  - Result appears with out_valid = 1 exactly 3 advancing cycles after accept. Throughput is 1 per cycle.
  - res/flags stay stable while out_valid && !out_ready.
- Stage 1 (align):
  - Apply sub to b's sign.
  - Order operands by magnitude: compare {exp, man}; on equality, a is taken as large.
  - d = exp_L - exp_S.
  - Build significands {hidden, man, G, R, S} (MAN_W+4 bits).
  - Shift small right by d; OR all shifted-out bits into S.
  - d >= MAN_W+3 saturates: small significand becomes 0, S = OR of all small bits.
  - Exp field 0 is treated as zero (denormals flush to zero on input).
- Stage 2 (add):
  - Effective op = sign_L XOR sign_S.
  - Add or subtract magnitudes into MAN_W+5 bits. The large-first ordering guarantees a non-negative result.
  - Compute leading-zero count of the sum.
- Stage 3 (normalise/round/pack):
  - Carry out: shift right 1, exp+1, old LSB ORed into sticky.
  - Otherwise: shift left by lzc, exp-lzc.
  - RNE: increment if G && (R || S || LSB).
  - Rounding carry: shift right 1, exp+1.
  - inexact = G||R||S before rounding.
- Boundaries:
  - Zero result from cancellation: +0.
  - (-0)+(-0) = -0.
  - Exp reaching all-ones: ±inf, overflow = 1, inexact = 1.
  - Exp <= 0 after normalise: ±0 (flush to zero), inexact = 1.
  - Any NaN input: canonical qNaN {0, all-ones, 1000...0}.
  - inf + (-inf): qNaN, invalid = 1.
  - inf op finite: that inf, no flags.
- Simultaneous in-accept and out-accept in the same cycle is legal and loses nothing.

Optional Feature:
- Macro: FP_ADD_PIPE_FLAGS_EN.
- Defined: flags port exists. Exception bits are carried down the pipeline and registered alongside res, reset to 0.
- Undefined: flags port and all flag logic are absent; res behaviour is identical.

Test Plan (EXP_W=8, MAN_W=23):
- a=0x3F800000, b=0x3F800000, sub=0 -> res=0x40000000, flags=000, out_valid 3 cycles after accept.
- a=0x3F800001, b=0x33800000 (tie, odd LSB) -> res=0x3F800002, inexact=1. a=0x3F800000 with the same b -> res=0x3F800000, inexact=1.
- a=0x3F800000, b=0x3F800000, sub=1 -> res=0x00000000. a=0x80000000, b=0x80000000 -> res=0x80000000.
- a=0x7F7FFFFF, b=0x7F7FFFFF -> res=0x7F800000, overflow=1. a=0x7F800000, b=0xFF800000 -> res=0x7FC00000, invalid=1.
- Sequence:
  - Hold out_ready=0 and drive in_valid=1 with 5 ops -> exactly 3 accepted; in_ready=0 from the cycle out_valid rises.
  - Release out_ready -> results exit in order, one per cycle, none lost or duplicated.
- Assert rst_n low while 2 ops are in flight -> out_valid=0 and res=0 immediately (asynchronous); no stale result after release.
